stack_frame_ctrl: RTL and testbench
===================================

STACK_FRAME_CTRL -- requirements
Module: stack_frame_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand stack data width in bits.
REQ-002 Parameter DEPTH, default 7; operand stack index width is DEPTH+1 bits.
REQ-003 Parameter FRAMES_LOG2, default 4; frame table holds 2**FRAMES_LOG2 entries.
REQ-004 clk  in  1  the single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  controller idle, command accepted when cmd_valid&&cmd_ready.
REQ-008 cmd_op  in  2  0=NOP, 1=CALL, 2=RETURN, 3=RETURN_VALUE.
REQ-009 cmd_nargs  in  DEPTH+1  CALL argument count.
REQ-010 stk_op  out  3  stack op: 0=NONE, 1=PUSH, 2=POP, 3=REPLACE, 4=INDEX_RESET, 5=INDEX_RESET_AND_PUSH.
REQ-011 stk_data  out  WIDTH  data to stack.
REQ-012 stk_new_index  out  DEPTH+1  new index to stack.
REQ-013 stk_underflow_limit  out  DEPTH+1  current frame base (registered).
REQ-014 stk_index  in  DEPTH+1  stack current index.
REQ-015 stk_out  in  WIDTH  stack top-of-stack (registered inside stack, valid cycle after op).
REQ-016 done  out  1  one-cycle pulse, command completed without error.
REQ-017 error  out  1  one-cycle pulse, command rejected; state unchanged.
REQ-018 err_code  out  2  0=none, 1=FRAME_OVERFLOW, 2=FRAME_UNDERFLOW, 3=ARG_UNDERFLOW; holds until next accepted command.
REQ-019 frame_depth  out  FRAMES_LOG2+1  number of live frames.

Function
REQ-020 FSM states IDLE, CALL, RET_CAP, RET_WAIT, RET_RESTORE, FINISH; cmd_ready=1 only in IDLE.
REQ-021 stk_op SHALL be NONE in every state except RET_RESTORE.
REQ-022 Frame entry = {saved_limit, saved_base}, each DEPTH+1 bits; table indexed by frame_depth.
REQ-023 NOP accepted: IDLE->FINISH; done pulses next cycle; no other effect.
REQ-024 CALL accepted: IDLE->CALL; in CALL, base=stk_index-cmd_nargs (nargs latched at accept).
REQ-025 CALL error ARG_UNDERFLOW if cmd_nargs > stk_index-stk_underflow_limit; checked before FRAME_OVERFLOW.
REQ-026 CALL error FRAME_OVERFLOW if frame_depth==2**FRAMES_LOG2.
REQ-027 CALL success: write {stk_underflow_limit, base} at frame_depth, frame_depth+1, stk_underflow_limit<=base, ->FINISH.
REQ-028 RETURN/RETURN_VALUE with frame_depth==0: error FRAME_UNDERFLOW, ->IDLE, nothing changed.
REQ-029 RETURN: RET_RESTORE issues INDEX_RESET with stk_new_index=saved_base.
REQ-030 RETURN_VALUE: RET_CAP issues NONE, RET_WAIT latches stk_out, RET_RESTORE issues INDEX_RESET_AND_PUSH with stk_data=latched value, stk_new_index=saved_base.
REQ-031 RETURN_VALUE with stk_index==stk_underflow_limit (empty frame) behaves as RETURN (no push).
REQ-032 RET_RESTORE: stk_underflow_limit<=saved_limit, frame_depth-1, ->FINISH.
REQ-033 FINISH: done=1 for one cycle, ->IDLE; error and done never both high.
REQ-034 Latency accept->done: NOP 1, CALL 2, RETURN 2, RETURN_VALUE 4 cycles.
REQ-035 cmd_valid while cmd_ready=0 is ignored; command inputs latched only at acceptance.

Reset
REQ-036 reset has priority over all activity, including mid-command; stack-side effects already issued are not undone.
REQ-037 Reset values: state IDLE, cmd_ready 1, stk_op NONE, stk_data 0, stk_new_index 0, stk_underflow_limit 0, frame_depth 0, done 0, error 0, err_code 0; frame table contents undefined.

Verification
REQ-038 stk_index=5, limit 0, CALL nargs=2 -> 2 cycles later done, stk_underflow_limit=3, frame_depth=1.
REQ-039 Then stk_index=7, top=0xA5, RETURN_VALUE -> RET_RESTORE drives op 5, new_index 3, data 0xA5; limit back to 0, depth 0, done at cycle 4.
REQ-040 frame_depth=0, RETURN -> error pulse, err_code 2, limit/depth unchanged.
REQ-041 16 successive CALL nargs=0 then 17th -> error, err_code 1, frame_depth=16.
REQ-042 stk_index=4, limit 3, CALL nargs=2 -> error, err_code 3, no table write.
REQ-043 reset asserted in RET_WAIT -> next cycle all REQ-037 values, cmd_ready 1.

Source files
------------

// File: rtl/stack_frame_ctrl_if.sv
// Command-side bundle of the stack frame controller.
// The requester drives the command fields. The controller answers with ready,
// a completion or error pulse, and the sticky error code.
interface stack_frame_ctrl_if #(
    parameter int DEPTH = 7
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [DEPTH:0]   cmd_nargs;
    logic             done;
    logic             error;
    logic [1:0]       err_code;

    modport master (
        output cmd_valid, cmd_op, cmd_nargs,
        input  cmd_ready, done, error, err_code
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_nargs,
        output cmd_ready, done, error, err_code
    );
endinterface

// File: rtl/stack_frame_ctrl.sv
// Call/return frame controller for an operand stack.
// Each CALL records {caller limit, frame base} in a small table and moves the
// underflow limit up to the new base. A RETURN pops that entry, rewinds the
// stack index to the base and, for RETURN_VALUE, pushes the old top of stack
// back. Errors leave all frame state untouched.
module stack_frame_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 7,
    parameter int FRAMES_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    stack_frame_ctrl_if.slave      cmd,
    output logic [2:0]             stk_op,
    output logic [WIDTH-1:0]       stk_data,
    output logic [DEPTH:0]         stk_new_index,
    output logic [DEPTH:0]         stk_underflow_limit,
    input  logic [DEPTH:0]         stk_index,
    input  logic [WIDTH-1:0]       stk_out,
    output logic [FRAMES_LOG2:0]   frame_depth
);

    localparam int IW     = DEPTH + 1;
    localparam int FRAMES = 2 ** FRAMES_LOG2;

    typedef enum logic [2:0] {
        S_IDLE, S_CALL, S_RET_CAP, S_RET_WAIT, S_RET_RESTORE, S_FINISH
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP, OP_CALL, OP_RETURN, OP_RETURN_VALUE
    } cmd_op_e;

    typedef enum logic [2:0] {
        STK_NONE, STK_PUSH, STK_POP, STK_REPLACE,
        STK_INDEX_RESET, STK_INDEX_RESET_AND_PUSH
    } stk_op_e;

    typedef enum logic [1:0] {
        ERR_NONE, ERR_FRAME_OVERFLOW, ERR_FRAME_UNDERFLOW, ERR_ARG_UNDERFLOW
    } err_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        nargs_q, nargs_d;
    logic                 rv_q, rv_d;          // restore must push the captured value
    logic [WIDTH-1:0]     value_q, value_d;
    logic [IW-1:0]        limit_q, limit_d;
    logic [FRAMES_LOG2:0] depth_q, depth_d;
    err_e                 err_code_q, err_code_d;

    logic [2*IW-1:0]      frame_mem [FRAMES];
    logic                 frame_we;
    logic [FRAMES_LOG2-1:0] wr_idx, rd_idx;
    logic [2*IW-1:0]      rd_entry;
    logic [IW-1:0]        saved_limit, saved_base;
    logic [IW-1:0]        avail, base;

    logic                 ready, done_p, error_p;
    err_e                 err_now;
    stk_op_e              stk_op_c;

    assign avail       = stk_index - limit_q;
    assign base        = stk_index - nargs_q;
    assign wr_idx      = depth_q[FRAMES_LOG2-1:0];
    assign rd_idx      = depth_q[FRAMES_LOG2-1:0] - FRAMES_LOG2'(1);
    assign rd_entry    = frame_mem[rd_idx];
    assign saved_limit = rd_entry[2*IW-1:IW];
    assign saved_base  = rd_entry[IW-1:0];

    // Next-state, stack commands and handshake outputs
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path leaves one unassigned, which would infer a latch.
        state_d       = state_q;
        nargs_d       = nargs_q;
        rv_d          = rv_q;
        value_d       = value_q;
        limit_d       = limit_q;
        depth_d       = depth_q;
        err_code_d    = err_code_q;
        frame_we      = 1'b0;
        ready         = 1'b0;
        done_p        = 1'b0;
        error_p       = 1'b0;
        err_now       = ERR_NONE;
        stk_op_c      = STK_NONE;
        stk_data      = '0;
        stk_new_index = '0;

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (cmd.cmd_valid) begin
                    err_code_d = ERR_NONE;
                    nargs_d    = cmd.cmd_nargs;
                    rv_d       = 1'b0;
                    case (cmd_op_e'(cmd.cmd_op))
                        OP_NOP:  state_d = S_FINISH;
                        OP_CALL: state_d = S_CALL;
                        default: begin
                            if (depth_q == '0) begin
                                state_d = S_RET_CAP;    // reported there as underflow
                            end else if (cmd_op_e'(cmd.cmd_op) == OP_RETURN_VALUE &&
                                         stk_index != limit_q) begin
                                rv_d    = 1'b1;
                                state_d = S_RET_CAP;
                            end else begin
                                state_d = S_RET_RESTORE; // plain return or empty frame
                            end
                        end
                    endcase
                end
            end

            S_CALL: begin
                if (nargs_q > avail) begin
                    error_p    = 1'b1;
                    err_now    = ERR_ARG_UNDERFLOW;
                    err_code_d = ERR_ARG_UNDERFLOW;
                    state_d    = S_IDLE;
                end else if (depth_q == (FRAMES_LOG2 + 1)'(FRAMES)) begin
                    error_p    = 1'b1;
                    err_now    = ERR_FRAME_OVERFLOW;
                    err_code_d = ERR_FRAME_OVERFLOW;
                    state_d    = S_IDLE;
                end else begin
                    frame_we = 1'b1;
                    depth_d  = depth_q + (FRAMES_LOG2 + 1)'(1);
                    limit_d  = base;
                    state_d  = S_FINISH;
                end
            end

            S_RET_CAP: begin
                if (depth_q == '0) begin
                    error_p    = 1'b1;
                    err_now    = ERR_FRAME_UNDERFLOW;
                    err_code_d = ERR_FRAME_UNDERFLOW;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_RET_WAIT;
                end
            end

            S_RET_WAIT: begin
                value_d = stk_out;
                state_d = S_RET_RESTORE;
            end

            S_RET_RESTORE: begin
                stk_op_c      = rv_q ? STK_INDEX_RESET_AND_PUSH : STK_INDEX_RESET;
                stk_new_index = saved_base;
                stk_data      = rv_q ? value_q : '0;
                limit_d       = saved_limit;
                depth_d       = depth_q - (FRAMES_LOG2 + 1)'(1);
                state_d       = S_FINISH;
            end

            S_FINISH: begin
                done_p  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Control and frame registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q    <= S_IDLE;
            nargs_q    <= '0;
            rv_q       <= 1'b0;
            value_q    <= '0;
            limit_q    <= '0;
            depth_q    <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            nargs_q    <= nargs_d;
            rv_q       <= rv_d;
            value_q    <= value_d;
            limit_q    <= limit_d;
            depth_q    <= depth_d;
            err_code_q <= err_code_d;
        end
    end

    // Frame table write on successful CALL
    always_ff @(posedge clk) begin
        // NOTE: the table is deliberately not reset; entries are only read below frame_depth, which always covers written slots.
        if (frame_we) begin
            frame_mem[wr_idx] <= {limit_q, base};
        end
    end

    assign stk_op              = stk_op_c;
    assign stk_underflow_limit = limit_q;
    assign frame_depth         = depth_q;
    assign cmd.cmd_ready       = ready;
    assign cmd.done            = done_p;
    assign cmd.error           = error_p;
    assign cmd.err_code        = error_p ? err_now : err_code_q;

endmodule

// File: tb/tb_stack_frame_ctrl.sv
// Self-checking bench for stack_frame_ctrl. The bench plays the operand stack
// and keeps a frame model as a queue of {limit, base} records. Expected
// responses go into scoreboard queues when a command is issued. A monitor pops
// and compares them whenever the DUT pulses done/error or drives a stack op.
module tb_stack_frame_ctrl;
    localparam int WIDTH = 8;
    localparam int DEPTH = 7;
    localparam int FL    = 4;
    localparam int NFR   = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stack_frame_ctrl_if #(.DEPTH(DEPTH)) cmd_if ();

    logic [2:0]       stk_op;
    logic [WIDTH-1:0] stk_data;
    logic [DEPTH:0]   stk_new_index;
    logic [DEPTH:0]   stk_underflow_limit;
    logic [DEPTH:0]   stk_index = '0;
    logic [WIDTH-1:0] stk_out = '0;
    logic [FL:0]      frame_depth;

    stack_frame_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES_LOG2(FL)) dut (
        .clk                 (clk),
        .reset               (reset),
        .cmd                 (cmd_if),
        .stk_op              (stk_op),
        .stk_data            (stk_data),
        .stk_new_index       (stk_new_index),
        .stk_underflow_limit (stk_underflow_limit),
        .stk_index           (stk_index),
        .stk_out             (stk_out),
        .frame_depth         (frame_depth)
    );

    typedef struct { bit is_err; int code; int limit; int depth; int cyc; } resp_t;
    typedef struct { int op; int idx; int data; int cyc; } sop_t;
    typedef struct { int limit; int base; } frame_t;

    resp_t  resp_q[$];
    sop_t   sop_q[$];
    frame_t frames[$];
    int     m_lim = 0;
    int     m_idx = 0;
    int     last_err = 0;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare DUT responses and stack commands against the scoreboard
    initial begin
        resp_t r;
        sop_t  s;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (cmd_if.done || cmd_if.error) begin
                    check("done_error_exclusive", 32'(cmd_if.done & cmd_if.error), 0);
                    if (resp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_response: done=%0b error=%0b, expected none", cmd_if.done, cmd_if.error);
                    end else begin
                        r = resp_q.pop_front();
                        check("resp_is_error", 32'(cmd_if.error), 32'(r.is_err));
                        check("resp_cycle",    cyc,                   r.cyc);
                        check("err_code",      32'(cmd_if.err_code),  r.code);
                        check("limit",         32'(stk_underflow_limit), r.limit);
                        check("frame_depth",   32'(frame_depth),      r.depth);
                        last_err = r.code;
                    end
                end else if (cmd_if.cmd_ready) begin
                    check("err_code_hold", 32'(cmd_if.err_code), last_err);
                end
                if (stk_op != 3'd0) begin
                    if (sop_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_stk_op: got op %0d, expected none", stk_op);
                    end else begin
                        s = sop_q.pop_front();
                        check("stk_op",        32'(stk_op),        s.op);
                        check("stk_new_index", 32'(stk_new_index), s.idx);
                        check("stk_data",      32'(stk_data),      s.data);
                        check("stk_op_cycle",  cyc,                s.cyc);
                    end
                end
            end
        end
    end

    // Present one command at a negedge and record what the model expects
    task automatic start_cmd(input int op, input int nargs, input int idx, input int top);
        int     w = 0;
        int     acc;
        bit     rv;
        resp_t  r;
        frame_t f;
        while (!cmd_if.cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_if.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: cmd_ready=0, expected 1 within 50 cycles");
        end
        stk_index        = DEPTH'(idx);
        stk_out          = WIDTH'(top);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'(op);
        cmd_if.cmd_nargs = (DEPTH+1)'(nargs);
        acc = cyc + 1;
        m_idx = idx;
        r.is_err = 1'b0;
        r.code   = 0;
        r.cyc    = acc;
        case (op)
            0: ;
            1: begin
                if (nargs > idx - m_lim) begin
                    r.is_err = 1'b1;
                    r.code   = 3;
                end else if (frames.size() == NFR) begin
                    r.is_err = 1'b1;
                    r.code   = 1;
                end else begin
                    f.limit = m_lim;
                    f.base  = idx - nargs;
                    frames.push_back(f);
                    m_lim = idx - nargs;
                    r.cyc = acc + 1;
                end
            end
            default: begin
                if (frames.size() == 0) begin
                    r.is_err = 1'b1;
                    r.code   = 2;
                end else begin
                    f  = frames.pop_back();
                    rv = (op == 3) && (idx != m_lim);
                    sop_q.push_back('{rv ? 5 : 4, f.base, rv ? top : 0, acc + (rv ? 2 : 0)});
                    m_lim = f.limit;
                    m_idx = f.base + (rv ? 1 : 0);
                    r.cyc = acc + (rv ? 3 : 1);
                end
            end
        endcase
        r.limit = m_lim;
        r.depth = frames.size();
        resp_q.push_back(r);
        @(negedge clk);
        // Busy-cycle garbage on the command inputs must be ignored
        cmd_if.cmd_op    = 2'($urandom);
        cmd_if.cmd_nargs = (DEPTH+1)'($urandom);
    endtask

    task automatic finish_cmd();
        int t = 0;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        while ((resp_q.size() != 0 || sop_q.size() != 0) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (resp_q.size() != 0 || sop_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL response_timeout: %0d responses and %0d stack ops outstanding, expected 0", resp_q.size(), sop_q.size());
            resp_q.delete();
            sop_q.delete();
        end
    endtask

    task automatic issue(input int op, input int nargs, input int idx, input int top);
        start_cmd(op, nargs, idx, top);
        finish_cmd();
    endtask

    task automatic check_reset_values();
        check("rst_cmd_ready", 32'(cmd_if.cmd_ready),   1);
        check("rst_stk_op",    32'(stk_op),             0);
        check("rst_stk_data",  32'(stk_data),           0);
        check("rst_new_index", 32'(stk_new_index),      0);
        check("rst_limit",     32'(stk_underflow_limit), 0);
        check("rst_depth",     32'(frame_depth),        0);
        check("rst_done",      32'(cmd_if.done),        0);
        check("rst_error",     32'(cmd_if.error),       0);
        check("rst_err_code",  32'(cmd_if.err_code),    0);
    endtask

    initial begin
        int op, idx, nargs;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = '0;
        cmd_if.cmd_nargs = '0;
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        @(negedge clk);

        // Call with two arguments, then return a value from that frame
        issue(1, 2, 5, 0);
        issue(3, 0, 7, 8'hA5);
        // Return with no live frame
        issue(2, 0, 3, 0);
        // Fill the frame table, then one call too many
        for (int i = 0; i < NFR + 1; i++) issue(1, 0, 4, 0);
        for (int i = 0; i < NFR; i++) issue(2, 0, m_idx, 0);
        // Argument underflow against a raised limit
        issue(1, 0, 3, 0);
        issue(1, 2, 4, 0);
        issue(2, 0, 3, 0);

        // Reset while a RETURN_VALUE sits in RET_WAIT
        issue(1, 1, 5, 0);
        start_cmd(3, 0, 6, 8'h3C);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        last_err = 0;
        reset = 1'b1;
        @(negedge clk);
        check_reset_values();
        resp_q.delete();
        sop_q.delete();
        frames.delete();
        m_lim = 0;
        reset = 1'b0;
        @(negedge clk);

        // Random command mix
        for (int n = 0; n < 400; n++) begin
            op  = $urandom_range(0, 3);
            idx = m_idx + $urandom_range(0, 3);
            if (idx > 250) idx = m_idx;
            nargs = $urandom_range(0, idx - m_lim + 1);
            issue(op, nargs, idx, $urandom_range(0, 255));
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
